// File: rtl/alu_ctrl_decoder.sv
// ---------------------------------------------------------------------------
// alu_ctrl_decoder
//
// RV32I decode stage placed between fetch and execute. The decoder turns an
// instruction word into the one-hot alu_control word for the core ALU. It also
// produces the operand-select flags, the register indices and the
// sign-extended immediate. All of these sit in one valid/ready pipeline
// register, which gives 1-cycle latency and full throughput.
//
// Ports:
//   clk, rst        core clock (rising edge), asynchronous active-high reset
//   in_valid        fetch presents inst/pc this cycle
//   in_ready        stage can accept inst this cycle (combinational)
//   inst, pc        instruction word and its address
//   flush           drop the held bundle and any incoming instruction
//   out_valid       decoded bundle valid
//   out_ready       execute accepts the bundle
//   alu_control     one-hot: [0]add [1]sub [2]slt [3]sltu [4]and [5]nor
//                   [6]or [7]xor [8]sll [9]srl [10]sra [11]lui
//   imm             sign-extended immediate (I/S/B/U/J, zero-extended shamt)
//   rs1_addr, rs2_addr, rd_addr   register indices taken from the inst fields
//   src2_is_imm     ALU operand B = imm, otherwise rs2
//   src1_is_pc      ALU operand A = pc (AUIPC, JAL)
//   src1_is_zero    ALU operand A = 0 (LUI)
//   swap_src        execute swaps the operands (the ALU shifts src2 by src1)
//   reg_write       writeback enable
//   illegal         unsupported encoding (bundle still delivered)
//   pc_out          registered pc
// ---------------------------------------------------------------------------
module alu_ctrl_decoder #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] inst,
    input  logic [XLEN-1:0] pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [11:0]     alu_control,
    output logic [XLEN-1:0] imm,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    output logic [4:0]      rd_addr,
    output logic            src2_is_imm,
    output logic            src1_is_pc,
    output logic            src1_is_zero,
    output logic            swap_src,
    output logic            reg_write,
    output logic            illegal,
    output logic [XLEN-1:0] pc_out
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [11:0] ALU_ADD  = 12'h001;
    localparam logic [11:0] ALU_SUB  = 12'h002;
    localparam logic [11:0] ALU_SLT  = 12'h004;
    localparam logic [11:0] ALU_SLTU = 12'h008;
    localparam logic [11:0] ALU_AND  = 12'h010;
    localparam logic [11:0] ALU_OR   = 12'h040;
    localparam logic [11:0] ALU_XOR  = 12'h080;
    localparam logic [11:0] ALU_SLL  = 12'h100;
    localparam logic [11:0] ALU_SRL  = 12'h200;
    localparam logic [11:0] ALU_SRA  = 12'h400;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_shamt;

    assign opcode    = inst[6:0];
    assign funct3    = inst[14:12];
    assign funct7    = inst[31:25];
    assign imm_i     = {{20{inst[31]}}, inst[31:20]};
    assign imm_s     = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b     = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u     = {inst[31:12], 12'h000};
    assign imm_j     = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    assign imm_shamt = {27'd0, inst[24:20]};

    // The funct3 map shared by OP and OP-IMM. Subtract and arithmetic
    // shift are selected by the caller.
    function automatic logic [11:0] base_op(input logic [2:0] f3);
        case (f3)
            3'b000:  base_op = ALU_ADD;
            3'b001:  base_op = ALU_SLL;
            3'b010:  base_op = ALU_SLT;
            3'b011:  base_op = ALU_SLTU;
            3'b100:  base_op = ALU_XOR;
            3'b101:  base_op = ALU_SRL;
            3'b110:  base_op = ALU_OR;
            default: base_op = ALU_AND;
        endcase
    endfunction

    logic [11:0]     dec_alu;
    logic [XLEN-1:0] dec_imm;
    logic            dec_src2_is_imm, dec_src1_is_pc, dec_src1_is_zero;
    logic            dec_swap, dec_writes, dec_illegal, dec_reg_write;

    // Combinational decode of the incoming word. Illegal paths set only
    // dec_illegal, so every other flag keeps its zero default.
    // LUI, AUIPC and JAL also select the immediate as operand B, because
    // the ALU computes 0+imm or pc+imm for these instructions.
    always_comb begin
        dec_alu          = 12'h000;
        dec_imm          = '0;
        dec_src2_is_imm  = 1'b0;
        dec_src1_is_pc   = 1'b0;
        dec_src1_is_zero = 1'b0;
        dec_swap         = 1'b0;
        dec_writes       = 1'b0;
        dec_illegal      = 1'b0;
        case (opcode)
            OPC_OP: begin
                if (funct7 == 7'b0000000) begin
                    dec_alu    = base_op(funct3);
                    dec_swap   = (funct3 == 3'b001) || (funct3 == 3'b101);
                    dec_writes = 1'b1;
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    dec_alu    = ALU_SUB;
                    dec_writes = 1'b1;
                end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
                    dec_alu    = ALU_SRA;
                    dec_swap   = 1'b1;
                    dec_writes = 1'b1;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                case (funct3)
                    3'b001: begin
                        if (funct7 == 7'b0000000) begin
                            dec_alu         = ALU_SLL;
                            dec_imm         = imm_shamt;
                            dec_src2_is_imm = 1'b1;
                            dec_swap        = 1'b1;
                            dec_writes      = 1'b1;
                        end else begin
                            dec_illegal = 1'b1;
                        end
                    end
                    3'b101: begin
                        // inst[30] picks arithmetic vs logical; all other funct7 bits must be 0
                        if (!inst[31] && inst[29:25] == 5'd0) begin
                            dec_alu         = inst[30] ? ALU_SRA : ALU_SRL;
                            dec_imm         = imm_shamt;
                            dec_src2_is_imm = 1'b1;
                            dec_swap        = 1'b1;
                            dec_writes      = 1'b1;
                        end else begin
                            dec_illegal = 1'b1;
                        end
                    end
                    default: begin
                        dec_alu         = base_op(funct3);
                        dec_imm         = imm_i;
                        dec_src2_is_imm = 1'b1;
                        dec_writes      = 1'b1;
                    end
                endcase
            end
            OPC_LUI: begin
                dec_alu          = ALU_ADD;
                dec_imm          = imm_u;
                dec_src1_is_zero = 1'b1;
                dec_src2_is_imm  = 1'b1;
                dec_writes       = 1'b1;
            end
            OPC_AUIPC: begin
                dec_alu         = ALU_ADD;
                dec_imm         = imm_u;
                dec_src1_is_pc  = 1'b1;
                dec_src2_is_imm = 1'b1;
                dec_writes      = 1'b1;
            end
            OPC_LOAD: begin
                if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) begin
                    dec_illegal = 1'b1;
                end else begin
                    dec_alu         = ALU_ADD;
                    dec_imm         = imm_i;
                    dec_src2_is_imm = 1'b1;
                    dec_writes      = 1'b1;
                end
            end
            OPC_STORE: begin
                if (funct3[2] || funct3 == 3'b011) begin
                    dec_illegal = 1'b1;
                end else begin
                    dec_alu         = ALU_ADD;
                    dec_imm         = imm_s;
                    dec_src2_is_imm = 1'b1;
                end
            end
            OPC_BRANCH: begin
                dec_imm = imm_b;
                case (funct3[2:1])
                    2'b00:   dec_alu = ALU_SUB;
                    2'b10:   dec_alu = ALU_SLT;
                    2'b11:   dec_alu = ALU_SLTU;
                    default: begin
                        dec_illegal = 1'b1;
                        dec_imm     = '0;
                    end
                endcase
            end
            OPC_JAL: begin
                dec_alu         = ALU_ADD;
                dec_imm         = imm_j;
                dec_src1_is_pc  = 1'b1;
                dec_src2_is_imm = 1'b1;
                dec_writes      = 1'b1;
            end
            OPC_JALR: begin
                if (funct3 == 3'b000) begin
                    dec_alu         = ALU_ADD;
                    dec_imm         = imm_i;
                    dec_src2_is_imm = 1'b1;
                    dec_writes      = 1'b1;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // A write to x0 is never useful, so it is suppressed here.
    assign dec_reg_write = dec_writes && !dec_illegal && (inst[11:7] != 5'd0);

    logic load;
    assign in_ready = !out_valid || out_ready;
    assign load     = in_valid && in_ready && !flush;

    // The pipeline register. flush only drops the valid bit. The payload is
    // reloaded only on an accepted instruction, so a stalled bundle stays
    // bit-stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid    <= 1'b0;
            alu_control  <= 12'h000;
            imm          <= '0;
            rs1_addr     <= 5'd0;
            rs2_addr     <= 5'd0;
            rd_addr      <= 5'd0;
            src2_is_imm  <= 1'b0;
            src1_is_pc   <= 1'b0;
            src1_is_zero <= 1'b0;
            swap_src     <= 1'b0;
            reg_write    <= 1'b0;
            illegal      <= 1'b0;
            pc_out       <= '0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (load) begin
                out_valid    <= 1'b1;
                alu_control  <= dec_alu;
                imm          <= dec_imm;
                rs1_addr     <= inst[19:15];
                rs2_addr     <= inst[24:20];
                rd_addr      <= inst[11:7];
                src2_is_imm  <= dec_src2_is_imm;
                src1_is_pc   <= dec_src1_is_pc;
                src1_is_zero <= dec_src1_is_zero;
                swap_src     <= dec_swap;
                reg_write    <= dec_reg_write;
                illegal      <= dec_illegal;
                pc_out       <= pc;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_ctrl_decoder.sv
// ---------------------------------------------------------------------------
// tb_alu_ctrl_decoder
//
// Self-checking bench for alu_ctrl_decoder. It runs directed scenarios first,
// then a randomized handshake/instruction mix. The random mix is checked
// against an instruction-level reference model and a one-entry expectation
// of the output register.
// ---------------------------------------------------------------------------
module tb_alu_ctrl_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] inst = 32'h0;
    logic [31:0] pc = 32'h0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [11:0] alu_control;
    logic [31:0] imm;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic        src2_is_imm, src1_is_pc, src1_is_zero, swap_src;
    logic        reg_write, illegal;
    logic [31:0] pc_out;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SRAI = 32'h40335293;
    localparam logic [31:0] I_LUI  = 32'h123450B7;
    localparam logic [31:0] I_NOP  = 32'h00000013;

    alu_ctrl_decoder #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .inst(inst), .pc(pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_control(alu_control), .imm(imm),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
        .src2_is_imm(src2_is_imm), .src1_is_pc(src1_is_pc),
        .src1_is_zero(src1_is_zero), .swap_src(swap_src),
        .reg_write(reg_write), .illegal(illegal), .pc_out(pc_out)
    );

    // Free-running 100 MHz-style clock
    always #5 clk = ~clk;

    // Hard stop, in case something upstream ever wedges the run
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Expected bundle: flags = {src2_is_imm, src1_is_pc, src1_is_zero, swap_src, reg_write, illegal}
    typedef struct packed {
        logic [11:0] alu;
        logic [31:0] imm;
        logic [14:0] regs;
        logic [5:0]  flags;
    } bundle_t;

    // Reinterpret an unsigned field of the given width as a signed value
    function automatic longint sx(input longint v, input int bits);
        return (v >= (longint'(1) << (bits - 1))) ? v - (longint'(1) << bits) : v;
    endfunction

    // Instruction-level reference model. ALU ops are indices into the
    // one-hot word: 0 add,1 sub,2 slt,3 sltu,4 and,6 or,7 xor,8 sll,9 srl,10 sra
    function automatic bundle_t model(input logic [31:0] w);
        bundle_t b;
        int      rmap[8];
        int      op;
        bit      legal, s2imm, s1pc, s1zero, swap, writes;
        longint  immv;
        int      f3, f7;
        rmap   = '{0, 8, 2, 3, 7, 9, 6, 4};
        f3     = int'(w[14:12]);
        f7     = int'(w[31:25]);
        op     = 0;
        legal  = 1'b0; s2imm = 1'b0; s1pc = 1'b0; s1zero = 1'b0;
        swap   = 1'b0; writes = 1'b0;
        immv   = 0;
        case (w[6:0])
            7'h33: begin
                legal = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
                op    = rmap[f3] + ((f7 == 32) ? 1 : 0);
                swap  = (f3 == 1 || f3 == 5);
                writes = 1'b1;
            end
            7'h13: begin
                if (f3 == 1)      legal = (f7 == 0);
                else if (f3 == 5) legal = (f7 == 0 || f7 == 32);
                else              legal = 1'b1;
                op     = rmap[f3] + ((f3 == 5 && f7 == 32) ? 1 : 0);
                swap   = (f3 == 1 || f3 == 5);
                immv   = swap ? longint'(w[24:20]) : sx(longint'(w[31:20]), 12);
                s2imm  = 1'b1;
                writes = 1'b1;
            end
            7'h37: begin
                legal = 1'b1; s1zero = 1'b1; s2imm = 1'b1; writes = 1'b1;
                immv  = longint'(w[31:12]) * 4096;
            end
            7'h17: begin
                legal = 1'b1; s1pc = 1'b1; s2imm = 1'b1; writes = 1'b1;
                immv  = longint'(w[31:12]) * 4096;
            end
            7'h03: begin
                legal = (f3 <= 2 || f3 == 4 || f3 == 5);
                s2imm = 1'b1; writes = 1'b1;
                immv  = sx(longint'(w[31:20]), 12);
            end
            7'h23: begin
                legal = (f3 <= 2);
                s2imm = 1'b1;
                immv  = sx(longint'(w[31:25]) * 32 + longint'(w[11:7]), 12);
            end
            7'h63: begin
                legal = (f3 != 2 && f3 != 3);
                op    = (f3 < 2) ? 1 : ((f3 < 6) ? 2 : 3);
                immv  = sx(longint'(w[31]) * 4096 + longint'(w[7]) * 2048 +
                           longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2, 13);
            end
            7'h6F: begin
                legal = 1'b1; s1pc = 1'b1; s2imm = 1'b1; writes = 1'b1;
                immv  = sx(longint'(w[31]) * 1048576 + longint'(w[19:12]) * 4096 +
                           longint'(w[20]) * 2048 + longint'(w[30:21]) * 2, 21);
            end
            7'h67: begin
                legal = (f3 == 0);
                s2imm = 1'b1; writes = 1'b1;
                immv  = sx(longint'(w[31:20]), 12);
            end
            default: legal = 1'b0;
        endcase
        b.regs = {w[19:15], w[24:20], w[11:7]};
        if (legal) begin
            b.alu   = 12'(1 << op);
            b.imm   = immv[31:0];
            b.flags = {s2imm, s1pc, s1zero, swap, (writes && w[11:7] != 5'd0), 1'b0};
        end else begin
            b.alu   = 12'h000;
            b.imm   = 32'h0;
            b.flags = 6'b000001;
        end
        return b;
    endfunction

    // Random instruction biased towards the supported opcodes and funct7 values
    function automatic logic [31:0] gen_inst();
        logic [31:0] w;
        logic [6:0]  opcs[9];
        int          k;
        opcs = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67};
        w = $urandom;
        k = $urandom_range(0, 9);
        if (k < 9) w[6:0] = opcs[k];
        if (k < 2) begin
            case ($urandom_range(0, 3))
                0: w[31:25] = 7'b0000000;
                1: w[31:25] = 7'b0100000;
                default: ;
            endcase
        end
        if (k == 8 && $urandom_range(0, 3) != 0) w[14:12] = 3'b000;
        if ($urandom_range(0, 7) == 0) w[11:7] = 5'd0;
        return w;
    endfunction

    // Present one instruction for one clock edge (fetch side only)
    task automatic send(input logic [31:0] i, input logic [31:0] p);
        in_valid = 1'b1;
        inst     = i;
        pc       = p;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Empty the stage so the next scenario starts with out_valid low
    task automatic drain();
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++;
        if ({alu_control, imm, pc_out, reg_write, illegal} !== 78'h0) begin
            n_fail++; $display("[TB] FAIL reset_outputs: alu=%h imm=%h pc=%h rw=%b ill=%b want all 0",
                                alu_control, imm, pc_out, reg_write, illegal);
        end
        #4 rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_add();
        out_ready = 1'b1;
        send(I_ADD, 32'h0000_0100);
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL add_valid: got %b want 1", out_valid); end
        n_checks++;
        if (alu_control !== 12'h001) begin n_fail++; $display("[TB] FAIL add_alu: got %h want 001", alu_control); end
        n_checks++;
        if ({rs1_addr, rs2_addr, rd_addr} !== {5'd1, 5'd2, 5'd3}) begin
            n_fail++; $display("[TB] FAIL add_regs: got %0d/%0d/%0d want 1/2/3", rs1_addr, rs2_addr, rd_addr);
        end
        n_checks++;
        if ({reg_write, swap_src, src2_is_imm, illegal} !== 4'b1000) begin
            n_fail++; $display("[TB] FAIL add_flags: rw/swap/s2i/ill got %b%b%b%b want 1000",
                                reg_write, swap_src, src2_is_imm, illegal);
        end
        n_checks++;
        if (pc_out !== 32'h100) begin n_fail++; $display("[TB] FAIL add_pc: got %h want 00000100", pc_out); end
    endtask

    task automatic test_srai();
        send(I_SRAI, 32'h0000_0104);
        n_checks++;
        if (alu_control !== 12'h400) begin n_fail++; $display("[TB] FAIL srai_alu: got %h want 400", alu_control); end
        n_checks++;
        if (imm !== 32'h3) begin n_fail++; $display("[TB] FAIL srai_imm: got %h want 00000003", imm); end
        n_checks++;
        if ({src2_is_imm, swap_src, rd_addr} !== {1'b1, 1'b1, 5'd5}) begin
            n_fail++; $display("[TB] FAIL srai_flags: s2i=%b swap=%b rd=%0d want 1 1 5", src2_is_imm, swap_src, rd_addr);
        end
    endtask

    task automatic test_lui();
        send(I_LUI, 32'h0000_0108);
        n_checks++;
        if (alu_control !== 12'h001) begin n_fail++; $display("[TB] FAIL lui_alu: got %h want 001", alu_control); end
        n_checks++;
        if (imm !== 32'h12345000) begin n_fail++; $display("[TB] FAIL lui_imm: got %h want 12345000", imm); end
        n_checks++;
        if ({src1_is_zero, src1_is_pc, reg_write} !== 3'b101) begin
            n_fail++; $display("[TB] FAIL lui_flags: zero/pc/rw got %b%b%b want 101", src1_is_zero, src1_is_pc, reg_write);
        end
        send(I_NOP, 32'h0000_010C);
        n_checks++;
        if ({reg_write, alu_control} !== {1'b0, 12'h001}) begin
            n_fail++; $display("[TB] FAIL nop_rd0: rw=%b alu=%h want rw=0 alu=001", reg_write, alu_control);
        end
    endtask

    task automatic test_back_to_back_stall();
        drain();
        out_ready = 1'b0;
        send(I_ADD, 32'h0000_0200);
        in_valid = 1'b1;
        inst     = I_SRAI;
        pc       = 32'h0000_0204;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_in_ready[%0d]: got %b want 0", c, in_ready); end
            @(posedge clk); #1;
            n_checks++;
            if ({out_valid, alu_control, pc_out, rd_addr} !== {1'b1, 12'h001, 32'h200, 5'd3}) begin
                n_fail++; $display("[TB] FAIL stall_hold[%0d]: v=%b alu=%h pc=%h rd=%0d want 1 001 00000200 3",
                                    c, out_valid, alu_control, pc_out, rd_addr);
            end
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL release_in_ready: got %b want 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, alu_control, pc_out} !== {1'b1, 12'h400, 32'h204}) begin
            n_fail++; $display("[TB] FAIL release_next: v=%b alu=%h pc=%h want 1 400 00000204", out_valid, alu_control, pc_out);
        end
    endtask

    task automatic test_flush_illegal();
        drain();
        out_ready = 1'b0;
        send(I_ADD, 32'h0000_0300);
        flush    = 1'b1;
        in_valid = 1'b1;
        inst     = I_SRAI;
        pc       = 32'h0000_0304;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_valid: got %b want 0", out_valid); end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_no_load: got %b want 0", out_valid); end
        send(32'hFFFF_FFFF, 32'h0000_0308);
        n_checks++;
        if ({out_valid, illegal, alu_control, reg_write} !== {1'b1, 1'b1, 12'h000, 1'b0}) begin
            n_fail++; $display("[TB] FAIL illegal_word: v=%b ill=%b alu=%h rw=%b want 1 1 000 0",
                                out_valid, illegal, alu_control, reg_write);
        end
    endtask

    task automatic test_reset_mid_stall();
        drain();
        out_ready = 1'b0;
        send(I_ADD, 32'h0000_0400);
        in_valid = 1'b1;
        inst     = I_SRAI;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({out_valid, alu_control, pc_out, rd_addr, reg_write} !== 51'h0) begin
            n_fail++; $display("[TB] FAIL async_reset: v=%b alu=%h pc=%h rd=%0d rw=%b want all 0",
                                out_valid, alu_control, pc_out, rd_addr, reg_write);
        end
        in_valid = 1'b0;
        #1 rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++; $display("[TB] FAIL after_reset: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_random();
        bit          exp_v;
        bundle_t     exp_b;
        logic [31:0] exp_pc, exp_inst;
        bit          rdy, ld;
        drain();
        drain();
        exp_v    = 1'b0;
        exp_b    = '0;
        exp_pc   = 32'h0;
        exp_inst = 32'h0;
        for (int n = 0; n < 800; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            inst      = gen_inst();
            pc        = $urandom & 32'hFFFF_FFFC;
            #1;
            rdy = !exp_v || out_ready;
            n_checks++;
            if (in_ready !== rdy) begin n_fail++; $display("[TB] FAIL rnd_in_ready[%0d]: got %b want %b", n, in_ready, rdy); end
            ld = in_valid && rdy && !flush;
            if (flush) exp_v = 1'b0;
            else if (ld) begin
                exp_v    = 1'b1;
                exp_b    = model(inst);
                exp_pc   = pc;
                exp_inst = inst;
            end else if (out_ready) exp_v = 1'b0;
            @(posedge clk); #1;
            n_checks++;
            if (out_valid !== exp_v) begin n_fail++; $display("[TB] FAIL rnd_valid[%0d]: got %b want %b", n, out_valid, exp_v); end
            if (exp_v) begin
                n_checks++;
                if (alu_control !== exp_b.alu) begin
                    n_fail++; $display("[TB] FAIL rnd_alu[%0d] inst=%h: got %h want %h", n, exp_inst, alu_control, exp_b.alu);
                end
                n_checks++;
                if (imm !== exp_b.imm) begin
                    n_fail++; $display("[TB] FAIL rnd_imm[%0d] inst=%h: got %h want %h", n, exp_inst, imm, exp_b.imm);
                end
                n_checks++;
                if ({rs1_addr, rs2_addr, rd_addr} !== exp_b.regs) begin
                    n_fail++; $display("[TB] FAIL rnd_regs[%0d] inst=%h: got %h want %h", n, exp_inst,
                                        {rs1_addr, rs2_addr, rd_addr}, exp_b.regs);
                end
                n_checks++;
                if ({src2_is_imm, src1_is_pc, src1_is_zero, swap_src, reg_write, illegal} !== exp_b.flags) begin
                    n_fail++; $display("[TB] FAIL rnd_flags[%0d] inst=%h: got %b want %b", n, exp_inst,
                                        {src2_is_imm, src1_is_pc, src1_is_zero, swap_src, reg_write, illegal}, exp_b.flags);
                end
                n_checks++;
                if (pc_out !== exp_pc) begin
                    n_fail++; $display("[TB] FAIL rnd_pc[%0d]: got %h want %h", n, pc_out, exp_pc);
                end
            end
        end
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    // Scenario sequence
    initial begin
        test_reset();
        test_add();
        test_srai();
        test_lui();
        test_back_to_back_stall();
        test_flush_illegal();
        test_reset_mid_stall();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_decoder.md
Name: alu_ctrl_decoder

Overview:
- RV32I decode stage that produces the 12-bit one-hot alu_control word consumed by the core ALU, plus operand-select flags, register addresses and the sign-extended immediate.
- Sits between fetch and execute. A single valid/ready pipeline register gives 1-cycle latency, full throughput and a flush input for redirects.

Parameters:
- XLEN, 32, datapath width of inst, pc and imm (fixed at 32; no other value supported)

Ports:
- clk  input  1  core clock, rising edge
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  inst/pc valid from fetch
- in_ready  output  1  stage can accept inst this cycle
- inst  input  32  instruction word
- pc  input  32  instruction address
- flush  input  1  discard held and incoming instruction
- out_valid  output  1  decoded bundle valid
- out_ready  input  1  execute accepts bundle
- alu_control  output  12  one-hot: [0]add [1]sub [2]slt [3]sltu [4]and [5]nor [6]or [7]xor [8]sll [9]srl [10]sra [11]lui
- imm  output  32  sign-extended immediate (I/S/B/U/J per opcode)
- rs1_addr, rs2_addr, rd_addr  output  5 each  register indices (inst[19:15], [24:20], [11:7])
- src2_is_imm  output  1  ALU operand B = imm, else rs2
- src1_is_pc  output  1  ALU operand A = pc (AUIPC, JAL)
- src1_is_zero  output  1  ALU operand A = 0 (LUI)
- swap_src  output  1  execute drives alu_src1 = operand B, alu_src2 = operand A (shifts)
- reg_write  output  1  writeback enable
- illegal  output  1  unsupported encoding
- pc_out  output  32  registered pc

Behaviour:
- Reset (async, any time, including mid-handshake): out_valid=0; every registered output = 0. in_ready=1 one cycle after rst deasserts.
- in_ready = ~out_valid | out_ready (combinational). Load when in_valid & in_ready & ~flush. All outputs registered, 1-cycle latency.
- out_valid next = flush ? 0 : (load ? 1 : (out_ready ? 0 : out_valid)).
- While out_valid & ~out_ready, all outputs hold stable.
- flush has priority over a simultaneous load and over a held bundle.
- Decode:
  - OP (0110011): funct3 selects add/sll/slt/sltu/xor/srl/or/and. funct7=0100000 is legal only with funct3 000 (sub) or 101 (sra). Any other funct7 is illegal.
  - OP-IMM (0010011): same map without sub. SLLI needs funct7=0000000. SRLI/SRAI use inst[30], with the remaining funct7 bits 0. src2_is_imm=1.
  - Shifts (reg and imm): swap_src=1, because the ALU shifts alu_src2 by alu_src1[4:0]. Shift imm = zero-extended shamt inst[24:20].
  - LUI: alu_control=add (bit 0, not bit 11, which is 16-bit only), src1_is_zero=1, imm={inst[31:12],12'h0}.
  - AUIPC: add, src1_is_pc, U-imm.
  - LOAD/STORE: add, src2_is_imm, I/S-imm. reg_write only for load.
  - BRANCH: beq/bne → sub; blt/bge → slt; bltu/bgeu → sltu. B-imm, reg_write=0. funct3 010/011 illegal.
  - JAL: add, src1_is_pc, J-imm. JALR (funct3=000): add, src2_is_imm, I-imm.
- reg_write forced 0 when rd_addr=0, for stores, for branches, and when illegal.
- Illegal (any other opcode or bad funct): alu_control=0, illegal=1, reg_write=0, other flags 0; the bundle is still passed with out_valid.
- alu_control is zero or exactly one bit set; bit 5 (nor) and bit 11 (lui) are never emitted.

Test Plan:
- Reset, then inst=0x002081B3 (add x3,x1,x2) → next cycle out_valid=1, alu_control=0x001, rs1=1, rs2=2, rd=3, reg_write=1, swap_src=0.
- inst=0x40335293 (srai x5,x6,3) → alu_control=0x400, imm=0x00000003, src2_is_imm=1, swap_src=1, rd=5.
- inst=0x123450B7 (lui x1,0x12345) → alu_control=0x001, imm=0x12345000, src1_is_zero=1; then 0x00000013 with rd=0 → reg_write=0.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 → in_ready=0, outputs frozen. out_ready=1 → held bundle consumed, next inst loaded the same cycle.
- flush=1 together with in_valid=1 while holding a bundle → next cycle out_valid=0. inst=0xFFFFFFFF → illegal=1, alu_control=0.
- Assert rst mid-stall → outputs clear immediately with no clock edge needed.
